// File: rtl/phy_tx_pkg.sv
// phy_tx_pkg: shared types and constants for the phy_tx lane scheduler.
//   sched_state_e : scheduler FSM encoding (SYNC preamble / RUN service)
//   K28_5         : default comma byte used for sync and idle fill
//   PHY_LANES     : number of parallel byte lanes feeding the serializer
package phy_tx_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  localparam logic [7:0] K28_5     = 8'hBC;
  localparam int         PHY_LANES = 4;

endpackage

// File: rtl/phy_tx_lane_sched_rr_pick4.sv
// rr_pick4: rotated priority search over four requesters.
//   req_i   : request vector, one bit per lane
//   ptr_i   : lane with highest priority this slot
//   found_o : at least one request is set
//   idx_o   : first requesting lane at or after ptr_i (mod 4)
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       found_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_i + k[1:0];
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/phy_tx_lane_sched.sv
// phy_tx_lane_sched: shares the phy_tx serializer between four byte lanes.
// After reset a SYNC_COUNT-byte comma preamble is sent, then lanes are served
// round-robin, one byte per serializer slot, in the clk_4f domain.
//   clk_4f, reset (async, active low)
//   sched_en                   : allow grants in RUN
//   data_in0..3 / valid_in0..3 : lane bytes and their presence
//   ready_out0..3              : combinational grant (lane byte accepted)
//   ser_ready                  : serializer consumes data_out this cycle
//   data_out/valid_out/lane_out/is_idle : registered byte toward serializer
//   state_out                  : 0 = SYNC, 1 = RUN
// Optional build macro PHY_SCHED_IDLE_FILL_EN: in RUN with no eligible lane,
// fill the slot with the comma byte instead of dropping valid_out.
module phy_tx_lane_sched
  import phy_tx_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_COUNT = 4,
  parameter logic [DATA_W-1:0] IDLE_BYTE  = DATA_W'(K28_5)
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              sched_en,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic              valid_in2,
  input  logic              valid_in3,
  output logic              ready_out0,
  output logic              ready_out1,
  output logic              ready_out2,
  output logic              ready_out3,
  input  logic              ser_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [1:0]        lane_out,
  output logic              is_idle,
  output logic              state_out
);

  sched_state_e                          state_q;
  logic [3:0]                            cnt_q, cnt_d;
  logic [1:0]                            ptr_q, ptr_d;
  logic [DATA_W-1:0]                     data_q;
  logic                                  valid_q, idle_q;
  logic [1:0]                            lane_q;

  logic [PHY_LANES-1:0][DATA_W-1:0]      lane_data;
  logic [PHY_LANES-1:0]                  req;
  logic                                  load, found, grant;
  logic [1:0]                            pick;

  assign lane_data = {data_in3, data_in2, data_in1, data_in0};
  // sched_en low looks to the arbiter exactly like no lane being valid.
  assign req   = {valid_in3, valid_in2, valid_in1, valid_in0} & {PHY_LANES{sched_en}};
  assign load  = !valid_q | ser_ready;
  assign grant = load & (state_q == RUN) & found;
  assign cnt_d = cnt_q + 4'd1;
  assign ptr_d = pick + 2'd1;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (pick)
  );

  assign ready_out0 = grant & (pick == 2'd0);
  assign ready_out1 = grant & (pick == 2'd1);
  assign ready_out2 = grant & (pick == 2'd2);
  assign ready_out3 = grant & (pick == 2'd3);

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      idle_q  <= 1'b0;
    end else if (load) begin
      case (state_q)
        SYNC: begin
          data_q  <= IDLE_BYTE;
          idle_q  <= 1'b1;
          valid_q <= 1'b1;
          lane_q  <= '0;
          cnt_q   <= cnt_d;
          if (cnt_d == 4'(SYNC_COUNT)) state_q <= RUN;
        end
        RUN: begin
          if (found) begin
            data_q  <= lane_data[pick];
            lane_q  <= pick;
            valid_q <= 1'b1;
            idle_q  <= 1'b0;
            ptr_q   <= ptr_d;
          end else begin
`ifdef PHY_SCHED_IDLE_FILL_EN
            data_q  <= IDLE_BYTE;
            valid_q <= 1'b1;
            idle_q  <= 1'b1;
`else
            valid_q <= 1'b0;
            idle_q  <= 1'b0;
`endif
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;
  assign is_idle   = idle_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Directed bench for phy_tx_lane_sched. Expected serializer bytes are queued
// as stimulus is applied; a negedge monitor pops one per consumed byte.
module tb_phy_tx_lane_sched;

  logic            clk_4f = 1'b0;
  logic            reset, sched_en, ser_ready;
  logic [3:0][7:0] dat;
  logic [3:0]      vld;
  logic            ready_out0, ready_out1, ready_out2, ready_out3;
  logic [7:0]      data_out;
  logic            valid_out, is_idle, state_out;
  logic [1:0]      lane_out;
  logic [3:0]      rdy;

  logic [10:0]     sb[$];
  int              nvec = 0;
  int              nerr = 0;
`ifdef PHY_SCHED_IDLE_FILL_EN
  localparam logic FILL = 1'b1;
`else
  localparam logic FILL = 1'b0;
`endif

  always #5 clk_4f = ~clk_4f;

  phy_tx_lane_sched dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .sched_en   (sched_en),
    .data_in0   (dat[0]),
    .data_in1   (dat[1]),
    .data_in2   (dat[2]),
    .data_in3   (dat[3]),
    .valid_in0  (vld[0]),
    .valid_in1  (vld[1]),
    .valid_in2  (vld[2]),
    .valid_in3  (vld[3]),
    .ready_out0 (ready_out0),
    .ready_out1 (ready_out1),
    .ready_out2 (ready_out2),
    .ready_out3 (ready_out3),
    .ser_ready  (ser_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .lane_out   (lane_out),
    .is_idle    (is_idle),
    .state_out  (state_out)
  );

  assign rdy = {ready_out3, ready_out2, ready_out1, ready_out0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] l, input logic idl);
    sb.push_back({d, l, idl});
  endtask

  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  // Four comma bytes; on the 4th load the FSM enters RUN and the first
  // grant (if any lane is valid) becomes visible combinationally.
  task automatic sync_phase(input logic [3:0] first_grant);
    for (int k = 1; k <= 4; k++) begin
      push(8'hBC, 2'd0, 1'b1);
      step();
      chk("sync_state", 32'(state_out), (k == 4) ? 32'd1 : 32'd0);
      chk("sync_ready", 32'(rdy), (k == 4) ? 32'(first_grant) : 32'd0);
    end
  endtask

  // Scoreboard monitor: a byte is consumed when valid_out & ser_ready.
  always @(negedge clk_4f) begin
    if (reset === 1'b1 && valid_out === 1'b1 && ser_ready === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL out_byte: unexpected %h lane %0d idle %0d", data_out, lane_out, is_idle);
      end else begin
        chk("out_byte", 32'({data_out, lane_out, is_idle}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, nothing expected");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ln;
    reset = 1'b0; sched_en = 1'b1; ser_ready = 1'b1; vld = '0; dat = '0;
    repeat (2) @(posedge clk_4f);
    #1;
    chk("rst_outs", 32'({data_out, valid_out, lane_out, is_idle, state_out}), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    reset = 1'b1;

    // Preamble with no lanes valid.
    sync_phase(4'b0000);

    // All lanes valid: strict rotation 0,1,2,3,0.
    dat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    vld = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      ln = 2'(i % 4);
      chk("rr_ready", 32'(rdy), 32'(4'b0001 << ln));
      push(8'hA0 + 8'(ln), ln, 1'b0);
      step();
    end

    // Single lane 2 gets every slot.
    vld = 4'b0100;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("solo_ready", 32'(rdy), 32'h4);
      push(8'hA2, 2'd2, 1'b0);
      step();
    end

    // Lane 1 granted, then 3 cycles of backpressure with lane 2 waiting.
    vld = 4'b0010; dat[1] = 8'hB1;
    #1;
    chk("bp_grant1", 32'(rdy), 32'h2);
    push(8'hB1, 2'd1, 1'b0);
    step();
    ser_ready = 1'b0; vld = 4'b0100; dat[2] = 8'hC2;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(rdy), 32'd0);
      chk("bp_hold", 32'({data_out, lane_out}), 32'({8'hB1, 2'd1}));
      step();
    end
    ser_ready = 1'b1;
    #1;
    chk("bp_release", 32'(rdy), 32'h4);
    push(8'hC2, 2'd2, 1'b0);
    step();

    // No lane valid in RUN.
    vld = 4'b0000;
    #1;
    chk("none_ready", 32'(rdy), 32'd0);
    if (FILL) push(8'hBC, 2'd2, 1'b1);
    step();
    chk("none_valid", 32'(valid_out), 32'(FILL));
    chk("none_idle", 32'(is_idle), 32'(FILL));

    // Lanes valid but scheduler disabled: same result.
    sched_en = 1'b0; vld = 4'b1111; dat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    chk("dis_ready", 32'(rdy), 32'd0);
    if (FILL) push(8'hBC, 2'd2, 1'b1);
    step();
    chk("dis_valid", 32'(valid_out), 32'(FILL));
    chk("dis_idle", 32'(is_idle), 32'(FILL));

    // Re-enable: pointer stayed at 3, so service is 3,0,1,2.
    sched_en = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      ln = 2'((3 + i) % 4);
      chk("resume_ready", 32'(rdy), 32'(4'b0001 << ln));
      push(8'hA0 + 8'(ln), ln, 1'b0);
      step();
    end
    chk("pre_reset_data", 32'(data_out), 32'hA2);

    // Mid-RUN reset: A2 is discarded, preamble restarts, lane 0 first.
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({data_out, valid_out, lane_out, is_idle, state_out}), 32'd0);
    chk("mid_rst_ready", 32'(rdy), 32'd0);
    void'(sb.pop_back());
    step();
    reset = 1'b1;
    sync_phase(4'b0001);
    for (int i = 0; i < 2; i++) begin
      ln = 2'(i);
      chk("restart_ready", 32'(rdy), 32'(4'b0001 << ln));
      push(8'hA0 + 8'(ln), ln, 1'b0);
      step();
    end

    vld = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (FILL) push(8'hBC, 2'd1, 1'b1);
      step();
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
